// File: rtl/bin2bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) with held display digits.
// Define BIN2BCD_BLANK_EN to blank leading zero digits of in-range results.
module bin2bcd_converter #(
    parameter int unsigned IN_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [IN_W-1:0] bin_in,
    output logic            ready,
    output logic            done,
    output logic            valid,
    output logic            overflow,
    output logic [3:0]      bcd_data_0,
    output logic [3:0]      bcd_data_1,
    output logic [3:0]      bcd_data_2,
    output logic [3:0]      bcd_data_3
);

    localparam int unsigned CntW = $clog2(IN_W + 1);
    localparam logic [IN_W-1:0] MaxVal = IN_W'(9999);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [IN_W-1:0] bin_q, bin_d;
    // Thousands digit is at most 4 before the final shift, so bit 15 never needs storing.
    logic [14:0]     bcd_q, bcd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     res_q, res_d;
    logic            ovf_q, ovf_d;
    logic            valid_q, valid_d;

    logic            in_range;
    logic            last_shift;
    logic [14:0]     bcd_adj;
    logic [15:0]     bcd_shift;
    logic [15:0]     res_fmt;

    assign in_range   = (bin_in <= MaxVal);
    assign last_shift = (cnt_q == CntW'(IN_W - 1));

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj, bin_q[IN_W-1]};
    end

    always_comb begin
        res_fmt = bcd_shift;
`ifdef BIN2BCD_BLANK_EN
        if (bcd_shift[15:12] == 4'd0) begin
            res_fmt[15:12] = 4'hF;
            if (bcd_shift[11:8] == 4'd0) begin
                res_fmt[11:8] = 4'hF;
                if (bcd_shift[7:4] == 4'd0) begin
                    res_fmt[7:4] = 4'hF;
                end
            end
        end
`else
        res_fmt = bcd_shift;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = in_range ? StShift : StDone;
            StShift: if (last_shift) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready = (state_q == StIdle);
        done  = (state_q == StDone);
    end

    // Result registers only change on the edge entering StDone, so the display never flickers.
    always_comb begin
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (in_range) begin
                        bin_d = bin_in;
                        bcd_d = '0;
                        cnt_d = '0;
                    end else begin
                        res_d   = 16'hAFFF;
                        ovf_d   = 1'b1;
                        valid_d = 1'b1;
                    end
                end
            end
            StShift: begin
                bin_d = {bin_q[IN_W-2:0], 1'b0};
                bcd_d = bcd_shift[14:0];
                cnt_d = cnt_q + CntW'(1);
                if (last_shift) begin
                    res_d   = res_fmt;
                    ovf_d   = 1'b0;
                    valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign valid      = valid_q;
    assign overflow   = ovf_q;
    assign bcd_data_0 = res_q[15:12];
    assign bcd_data_1 = res_q[11:8];
    assign bcd_data_2 = res_q[7:4];
    assign bcd_data_3 = res_q[3:0];

endmodule

// File: doc/bin2bcd_converter.md
BIN2BCD_CONVERTER -- requirements
Module: bin2bcd_converter

Interface
REQ-001 SHALL provide parameter IN_W, default 16, binary input width (legal range 14..16).
REQ-002 SHALL provide port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port start  input  1  conversion request, sampled on clk.
REQ-005 SHALL provide port bin_in  input  IN_W  unsigned binary value, sampled when start is accepted.
REQ-006 SHALL provide port ready  output  1  high when idle and able to accept start.
REQ-007 SHALL provide port done  output  1  one-cycle pulse when a new result is presented.
REQ-008 SHALL provide port valid  output  1  result registers hold a completed conversion; drives the display valid input.
REQ-009 SHALL provide port overflow  output  1  last result was out of range (bin_in > 9999).
REQ-010 SHALL provide ports bcd_data_0..bcd_data_3  output  4 each  digit codes; bcd_data_0 = thousands (leftmost), bcd_data_3 = units.

Function
REQ-011 SHALL implement a state machine with states IDLE, SHIFT and DONE.
REQ-012 IDLE: ready=1; start=1 captures bin_in and goes to SHIFT, or directly to DONE if bin_in > 9999.
REQ-013 SHIFT: SHALL run the shift-add-3 (double dabble) algorithm, one input bit per cycle, MSB first, for exactly IN_W cycles.
REQ-014 Each SHIFT cycle: add 3 to every 4-bit BCD nibble >= 5, then shift {bcd, bin} left by one.
REQ-015 DONE: lasts one cycle; done=1; result registers and overflow update; valid set to 1; next state IDLE.
REQ-016 Latency: start accepted in cycle T -> done and new digits in cycle T+IN_W+1 (T+17 for IN_W=16); overflow case -> cycle T+1.
REQ-017 Overflow result: bcd_data_0=10 (E), bcd_data_1..3=15 (blank), overflow=1.
REQ-018 In-range result: overflow=0; digits 0..9.
REQ-019 start while not in IDLE SHALL be ignored (no queuing); bin_in changes outside the capture cycle SHALL have no effect.
REQ-020 Result registers SHALL hold the previous result, with valid unchanged, throughout a conversion (no display flicker).
REQ-021 start=1 in the IDLE cycle that directly follows DONE SHALL be accepted.
REQ-022 Bits of bin_in above bit 13 SHALL only ever cause the overflow path.

Reset
REQ-023 On rst_n low: state IDLE, ready=1, done=0, valid=0, overflow=0, all bcd_data_*=0, internal shift registers cleared.
REQ-024 Reset asserted mid-SHIFT SHALL abort the conversion; no done pulse after release.
REQ-025 First start is accepted in the first clk edge with rst_n high.

Configuration
REQ-026 Macro BIN2BCD_BLANK_EN defined: leading-zero digits of an in-range result SHALL be output as 15 (blank); units digit never blanked (0 -> 15,15,15,0).
REQ-027 Macro BIN2BCD_BLANK_EN undefined: all four digits SHALL be output as numeric 0..9 (0 -> 0,0,0,0); overflow pattern unaffected.

Verification
REQ-028 Reset, then start with bin_in=1234 -> done at T+17; digits 1,2,3,4; valid=1; overflow=0.
REQ-029 bin_in=9999 then bin_in=10000 -> first 9,9,9,9 with overflow=0; second at T+1 gives 10,15,15,15 with overflow=1.
REQ-030 bin_in=7 -> macro undefined: 0,0,0,7; BIN2BCD_BLANK_EN: 15,15,15,7. bin_in=0 with macro -> 15,15,15,0.
REQ-031 start pulsed again at T+5 during a conversion of 4321 -> ignored; single done at T+17 with 4,3,2,1; digits hold prior value until then.
REQ-032 rst_n low at T+8 of a conversion -> all outputs at reset values; no done pulse; next start of 56 gives 0,0,5,6 (or 15,15,5,6 with BIN2BCD_BLANK_EN).
REQ-033 Back-to-back: start held high continuously with bin_in=42 -> a done pulse every IN_W+2 cycles, digits 0,0,4,2 stable.
